// File: rtl/signal_period_meter.sv
// Measures period and high time of a slow asynchronous input in CLK cycles.
// Input is synchronised and glitch-filtered; a stall flag is raised when no rising edge arrives in time.
module signal_period_meter #(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT_CYC = 5_000_000,
    parameter int FILT_LEN    = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             SIG_IN,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME,
    output logic             PERIOD_VALID,
    output logic             STALL
);

    localparam int FILT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_STALLED
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               filt_q, filt_d;
    logic               filt_prev_q, filt_prev_d;
    logic [FILT_W-1:0]  filt_cnt_q, filt_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic               valid_q, valid_d;
    logic               stall_q, stall_d;
    logic               rise, fall;

    // Filter: flip only after FILT_LEN consecutive samples disagree with the current level
    always_comb begin
        sync1_d     = SIG_IN;
        sync2_d     = sync1_q;
        filt_prev_d = filt_q;
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d = sync2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign rise = filt_q & ~filt_prev_q;
    assign fall = ~filt_q & filt_prev_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        stall_d  = stall_q;
        if (!EN) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            shadow_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_STALLED: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d  = S_MEASURE;
                        cnt_d    = CNT_ONE;
                        shadow_d = '0;
                    end
                end
                S_MEASURE: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = shadow_q;
                        valid_d  = 1'b1;
                        stall_d  = 1'b0;
                        cnt_d    = CNT_ONE;
                        shadow_d = '0;
                    end else if (cnt_q == TIMEOUT) begin
                        state_d  = S_STALLED;
                        cnt_d    = '0;
                        period_d = '0;
                        high_d   = '0;
                        stall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (fall) begin
                            shadow_d = cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            filt_cnt_q  <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            filt_cnt_q  <= filt_cnt_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            stall_q     <= stall_d;
        end
    end

    assign PERIOD       = period_q;
    assign HIGH_TIME    = high_q;
    assign PERIOD_VALID = valid_q;
    assign STALL        = stall_q;

endmodule
